// File: rtl/rx_chain_model_n.sv
// rx_chain_model_n: selectable DDS source, integrate-and-dump decimator with
// a deterministic test-pattern mode, feeding an AXI-stream master through a
// small output FIFO with sticky overflow reporting.
module rx_chain_model_n #(
  parameter int DDS_N      = 3,
  parameter int DDS_W      = 18,
  parameter int SRC_W      = 2,
  parameter int RATE_W     = 10,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [RATE_W-1:0]             rate_i,
  input  logic [DDS_N*DDS_W-1:0]        dds_i,
  input  logic [SRC_W-1:0]              dds_source_i,
  input  logic                          axis_tready_i,
  output logic                          axis_tvalid_o,
  output logic [OUT_W-1:0]              axis_tdata_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Window state
  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic [RATE_W-1:0] d_q, d_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [RATE_W-1:0] d_eff_s;
  logic [SRC_W-1:0]  src_eff_s;
  logic              win_end_s;
  logic              pattern_s;

  // Datapath state
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]  pat_q, pat_d;
  logic [DDS_W-1:0]  samp_raw_s;
  logic [OUT_W-1:0]  samp_s;
  logic              push_s;
  logic [OUT_W-1:0]  push_data_s;

  // FIFO state
  logic [OUT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [OUT_W-1:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       fill_q, fill_d;
  logic              ovf_q, ovf_d;
  logic              pop_s;
  logic              full_s;
  logic              wr_en_s;
  logic              drop_s;

  // Window configuration: rate and source are taken live on the first cycle
  // of a window and held from the latched copies for the rest of it.
  always_comb begin
    d_eff_s   = d_q;
    src_eff_s = src_q;
    if (cnt_q == '0) begin
      d_eff_s   = (rate_i == '0) ? RATE_W'(1) : rate_i;
      src_eff_s = dds_source_i;
    end else begin
      d_eff_s   = d_q;
      src_eff_s = src_q;
    end
    d_d       = d_eff_s;
    src_d     = src_eff_s;
    win_end_s = (cnt_q == (d_eff_s - RATE_W'(1)));
    if (win_end_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + RATE_W'(1);
    end
    pattern_s = (32'(src_eff_s) >= 32'(DDS_N));
  end

  // Source mux and sign extension of the selected DDS sample.
  always_comb begin
    samp_raw_s = '0;
    for (int s = 0; s < DDS_N; s++) begin
      if (32'(src_eff_s) == 32'(s)) begin
        samp_raw_s = dds_i[s*DDS_W +: DDS_W];
      end else begin
        samp_raw_s = samp_raw_s;
      end
    end
    samp_s = OUT_W'($signed(samp_raw_s));
  end

  // Integrate-and-dump / pattern generator producing at most one push per cycle.
  always_comb begin
    acc_d       = acc_q;
    pat_d       = pat_q;
    push_s      = 1'b0;
    push_data_s = '0;
    if (pattern_s) begin
      acc_d = '0;
      if (win_end_s) begin
        push_s      = 1'b1;
        push_data_s = pat_q;
        pat_d       = pat_q + OUT_W'(1);
      end else begin
        pat_d = pat_q;
      end
    end else begin
      if (win_end_s) begin
        push_s      = 1'b1;
        push_data_s = acc_q + samp_s;
        acc_d       = '0;
      end else begin
        acc_d = acc_q + samp_s;
      end
    end
  end

  // FIFO control: a push into a full FIFO survives only if the head is
  // leaving on the same edge; otherwise it is dropped and flagged.
  always_comb begin
    pop_s   = (fill_q != '0) && axis_tready_i;
    full_s  = (fill_q == (AW+1)'(FIFO_DEPTH));
    wr_en_s = push_s && (!full_s || pop_s);
    drop_s  = push_s && full_s && !pop_s;
    mem_d   = mem_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = push_data_s;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, pop_s})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
    ovf_d = ovf_q | drop_s;
  end

  // Control and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      d_q      <= RATE_W'(1);
      src_q    <= '0;
      acc_q    <= '0;
      pat_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      src_q    <= src_d;
      acc_q    <= acc_d;
      pat_q    <= pat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Output drive: head word is forced to zero while the FIFO is empty.
  always_comb begin
    axis_tvalid_o = (fill_q != '0);
    if (fill_q != '0) begin
      axis_tdata_o = mem_q[rd_ptr_q];
    end else begin
      axis_tdata_o = '0;
    end
    overflow_o = ovf_q;
    fill_o     = fill_q;
  end

endmodule

// File: tb/tb_rx_chain_model_n.sv
// Self-checking bench for rx_chain_model_n: a table of steady-state
// decimation vectors plus hand-written backpressure, rate-change and reset
// sequences, with expected words queued as they are produced.
module tb_rx_chain_model_n;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rate_i;
  logic [53:0] dds_i;
  logic [1:0]  dds_source_i;
  logic        axis_tready_i;
  logic        axis_tvalid_o;
  logic [31:0] axis_tdata_o;
  logic        overflow_o;
  logic [4:0]  fill_o;

  int n_tests;
  int n_fail;
  int edge_n;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [9:0]  rate;
    logic [1:0]  src;
    logic [17:0] s0;
    logic [17:0] s1;
    logic [17:0] s2;
    int          d;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[5];

  rx_chain_model_n dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rate_i        (rate_i),
    .dds_i         (dds_i),
    .dds_source_i  (dds_source_i),
    .axis_tready_i (axis_tready_i),
    .axis_tvalid_o (axis_tvalid_o),
    .axis_tdata_o  (axis_tdata_o),
    .overflow_o    (overflow_o),
    .fill_o        (fill_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic set_dds(input logic [17:0] s0, input logic [17:0] s1, input logic [17:0] s2);
    dds_i = {s2, s1, s0};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n  = 1'b1;
    edge_n = 0;
    exp_q.delete();
    check("rst_tvalid", 64'(axis_tvalid_o), 64'd0);
    check("rst_tdata", 64'(axis_tdata_o), 64'd0);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    check("rst_fill", 64'(fill_o), 64'd0);
  endtask

  // Compare the head against the scoreboard; tready is high so it leaves next edge.
  task automatic check_word(input string name, input logic exp_valid);
    logic [31:0] w;
    check({name, "_tvalid"}, 64'(axis_tvalid_o), 64'(exp_valid));
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      if (axis_tvalid_o) check({name, "_tdata"}, 64'(axis_tdata_o), 64'(w));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    edge_n  = 0;
    rst_n         = 1'b0;
    rate_i        = 10'd1;
    dds_source_i  = 2'd0;
    axis_tready_i = 1'b1;
    dds_i         = 54'd0;

    vecs[0] = '{rate: 10'd4, src: 2'd1, s0: 18'd0,       s1: 18'd100, s2: 18'd0,       d: 4, word: 32'd400};
    vecs[1] = '{rate: 10'd2, src: 2'd0, s0: 18'h3FFFD,   s1: 18'd0,   s2: 18'd0,       d: 2, word: 32'hFFFFFFFA};
    vecs[2] = '{rate: 10'd2, src: 2'd2, s0: 18'd0,       s1: 18'd0,   s2: 18'h1FFFF,   d: 2, word: 32'h0003FFFE};
    vecs[3] = '{rate: 10'd0, src: 2'd1, s0: 18'd5,       s1: 18'd7,   s2: 18'd9,       d: 1, word: 32'd7};
    vecs[4] = '{rate: 10'd3, src: 2'd2, s0: 18'd1,       s1: 18'd1,   s2: 18'h3FFFF,   d: 3, word: 32'hFFFFFFFD};

    // Steady-state decimation vectors with tready held high.
    for (int v = 0; v < 5; v++) begin
      rate_i        = vecs[v].rate;
      dds_source_i  = vecs[v].src;
      axis_tready_i = 1'b1;
      set_dds(vecs[v].s0, vecs[v].s1, vecs[v].s2);
      do_reset();
      for (int e = 1; e <= 12; e++) begin
        step();
        if (e % vecs[v].d == 0) exp_q.push_back(vecs[v].word);
        check_word("vec", (e % vecs[v].d) == 0);
        if (vecs[v].d == 1) check("vec_fill_d1", 64'(fill_o), 64'd1);
      end
      check("vec_overflow", 64'(overflow_o), 64'd0);
    end

    // Backpressure and overflow in pattern mode at D = 1.
    rate_i = 10'd1; dds_source_i = 2'd3; axis_tready_i = 1'b0;
    set_dds(18'd0, 18'd0, 18'd0);
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e <= 16) exp_q.push_back(32'(e - 1));
      check("bp_fill", 64'(fill_o), 64'((e < 16) ? e : 16));
      check("bp_overflow", 64'(overflow_o), 64'(e >= 17));
    end
    axis_tready_i = 1'b1;
    for (int j = 0; j < 24; j++) begin
      check_word("drain", 1'b1);
      check("drain_overflow", 64'(overflow_o), 64'd1);
      check("drain_fill", 64'(fill_o), 64'd16);
      step();
      exp_q.push_back(32'(edge_n - 1));
    end

    // Full FIFO with push and pop on the same edge: nothing is dropped.
    axis_tready_i = 1'b0;
    do_reset();
    for (int e = 1; e <= 16; e++) step();
    check("full_fill", 64'(fill_o), 64'd16);
    check("full_overflow", 64'(overflow_o), 64'd0);
    axis_tready_i = 1'b1;
    for (int e = 0; e < 4; e++) begin
      step();
      check("pp_fill", 64'(fill_o), 64'd16);
      check("pp_overflow", 64'(overflow_o), 64'd0);
      check("pp_head", 64'(axis_tdata_o), 64'(e + 1));
    end

    // Rate change from 4 to 2 during the first window.
    rate_i = 10'd4; dds_source_i = 2'd1; axis_tready_i = 1'b1;
    set_dds(18'd0, 18'd1, 18'd0);
    do_reset();
    step();
    check_word("rc", 1'b0);
    rate_i = 10'd2;
    for (int e = 2; e <= 12; e++) begin
      step();
      if (e == 4) exp_q.push_back(32'd4);
      else if (e > 4 && e % 2 == 0) exp_q.push_back(32'd2);
      check_word("rc", (e == 4) || (e > 4 && e % 2 == 0));
    end

    // Reset while the FIFO holds 5 words and overflow is set.
    rate_i = 10'd1; dds_source_i = 2'd3; axis_tready_i = 1'b0;
    do_reset();
    for (int e = 1; e <= 17; e++) step();
    rate_i = 10'd4; axis_tready_i = 1'b1;
    begin
      int budget;
      budget = 0;
      while (fill_o != 5'd5 && budget < 40) begin
        step();
        budget++;
      end
      check("rm_fill_reached", 64'(fill_o), 64'd5);
    end
    check("rm_overflow_pre", 64'(overflow_o), 64'd1);
    rate_i = 10'd1;
    do_reset();
    step();
    check("rm_first_valid", 64'(axis_tvalid_o), 64'd1);
    check("rm_first_word", 64'(axis_tdata_o), 64'd0);
    step();
    check("rm_second_word", 64'(axis_tdata_o), 64'd1);
    check("rm_overflow_post", 64'(overflow_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
